// File: rtl/encoder_32to5_rr.sv
// encoder_32to5_rr
//
// Round-robin 32-to-5 request encoder with a one-deep output register.
// Requests are OR-merged into a registered pending set. Whenever the
// output slot is free, or is being accepted this edge, one pending
// request is granted. The search starts at the rotating pointer and
// wraps mod 32. The granted bit is removed from the pending set and
// its binary index is presented on idx_out with a valid/ready handshake.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high reset
//   req_in     in  32   request vector, bit i requests index i
//   req_load   in   1   merge req_in into pending at the edge
//   idx_ready  in   1   consumer accepts idx_out when idx_valid is high
//   idx_out    out  5   granted index
//   idx_valid  out  1   idx_out holds a granted, not yet accepted index
//   pending    out 32   registered set of requests not yet granted
//   empty      out  1   nothing pending and nothing held on the output

module encoder_32to5_rr (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_in,
    input  logic        req_load,
    input  logic        idx_ready,
    output logic [4:0]  idx_out,
    output logic        idx_valid,
    output logic [31:0] pending,
    output logic        empty
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]  state;
    logic [4:0]  ptr;
    logic [4:0]  grant_idx;
    logic [4:0]  cand;
    logic        any_pending;
    logic        slot_open;
    logic        take;
    logic [31:0] grant_onehot;
    logic [31:0] load_bits;

    // Round-robin search over the registered pending set only, so a
    // request arriving this cycle can never be granted on the same edge.
    // Offsets are scanned from high to low so that the smallest offset
    // from ptr is the one left in grant_idx. The 5-bit add wraps mod 32.
    always_comb begin
        grant_idx = 5'd0;
        cand      = 5'd0;
        for (int k = 31; k >= 0; k--) begin
            cand = ptr + 5'(k);
            if (pending[cand]) begin
                grant_idx = cand;
            end
        end
    end

    // The slot is open when nothing is held, or when the held index is
    // accepted on this edge. idx_ready is irrelevant in EMPTY.
    always_comb begin
        any_pending  = |pending;
        slot_open    = (state == EMPTY) || idx_ready;
        take         = slot_open && any_pending;
        grant_onehot = take ? (32'd1 << grant_idx) : 32'd0;
        load_bits    = req_load ? req_in : 32'd0;
    end

    // Clear is applied before set, so a bit that is granted and
    // re-requested on the same edge stays pending for a later grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 32'd0;
            ptr     <= 5'd0;
            idx_out <= 5'd0;
            state   <= EMPTY;
        end else begin
            pending <= (pending & ~grant_onehot) | load_bits;
            if (take) begin
                idx_out <= grant_idx;
                state   <= HOLD;
                ptr     <= grant_idx + 5'd1;
            end else if (slot_open) begin
                state   <= EMPTY;
            end
        end
    end

    assign idx_valid = (state == HOLD);
    assign empty     = (pending == 32'd0) && (state == EMPTY);

endmodule

// File: tb/tb_encoder_32to5_rr.sv
// tb_encoder_32to5_rr
//
// Directed bench for encoder_32to5_rr. It uses a table of per-cycle
// vectors for load/drain with pointer wrap, followed by hand-written
// sequences for wrap search, backpressure, same-edge clear/set and
// reset during operation.

module tb_encoder_32to5_rr;

    logic        clk;
    logic        reset;
    logic [31:0] req_in;
    logic        req_load;
    logic        idx_ready;
    logic [4:0]  idx_out;
    logic        idx_valid;
    logic [31:0] pending;
    logic        empty;

    int checks_total;
    int checks_passed;

    typedef struct {
        logic        load;
        logic [31:0] req;
        logic        ready;
        logic [4:0]  exp_idx;
        logic        exp_valid;
        logic [31:0] exp_pending;
        logic        exp_empty;
    } vec_t;

    vec_t vecs [8];

    encoder_32to5_rr dut (
        .clk       (clk),
        .reset     (reset),
        .req_in    (req_in),
        .req_load  (req_load),
        .idx_ready (idx_ready),
        .idx_out   (idx_out),
        .idx_valid (idx_valid),
        .pending   (pending),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs and then advance one rising edge. Outputs are
    // sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic rst, input logic load,
                                 input logic [31:0] req, input logic ready);
        reset     = rst;
        req_load  = load;
        req_in    = req;
        idx_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOne(input string name, input string field,
                            input logic [31:0] act, input logic [31:0] req);
        checks_total++;
        if (act === req) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s %s: actual=0x%08h required=0x%08h",
                     name, field, act, req);
        end
    endtask

    task automatic checkOutput(input string name, input logic [4:0] e_idx,
                               input logic e_valid, input logic [31:0] e_pend,
                               input logic e_empty);
        checkOne(name, "idx_out", {27'd0, idx_out}, {27'd0, e_idx});
        checkOne(name, "idx_valid", {31'd0, idx_valid}, {31'd0, e_valid});
        checkOne(name, "pending", pending, e_pend);
        checkOne(name, "empty", {31'd0, empty}, {31'd0, e_empty});
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("reset", 5'd0, 1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset     = 1'b1;
        req_load  = 1'b0;
        req_in    = 32'd0;
        idx_ready = 1'b0;

        // load 0x8000_0011 and drain it: 0, 4, 31, then ptr has wrapped
        // to 0, so a fresh request at bit 0 is granted next
        vecs[0] = '{1'b1, 32'h8000_0011, 1'b1, 5'd0,  1'b0, 32'h8000_0011, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0000, 1'b1, 5'd0,  1'b1, 32'h8000_0010, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 5'd4,  1'b1, 32'h8000_0000, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0000, 1'b1, 5'd31, 1'b1, 32'h0000_0000, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 5'd31, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0001, 1'b1, 5'd31, 1'b0, 32'h0000_0001, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0000, 1'b1, 5'd0,  1'b1, 32'h0000_0000, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_0000, 1'b1, 5'd0,  1'b0, 32'h0000_0000, 1'b1};

        // single request, two-edge latency, then ptr=1 shown by order
        doReset();
        applyStimulus(1'b0, 1'b1, 32'h0000_0001, 1'b1);
        checkOutput("single_load", 5'd0, 1'b0, 32'h1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("single_grant", 5'd0, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("single_drain", 5'd0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0003, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("ptr1_first", 5'd1, 1'b1, 32'h1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("ptr1_second", 5'd0, 1'b1, 32'h0, 1'b0);

        // table-driven drain with pointer wrap
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, vecs[i].load, vecs[i].req, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_idx,
                        vecs[i].exp_valid, vecs[i].exp_pending, vecs[i].exp_empty);
        end

        // wrap search from ptr=5, with bit 6 loaded while draining
        doReset();
        applyStimulus(1'b0, 1'b1, 32'h0000_0010, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0009, 1'b1);
        checkOutput("wrap_g4", 5'd4, 1'b1, 32'h0000_0009, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        checkOutput("wrap_g0", 5'd0, 1'b1, 32'h0000_0048, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_g3", 5'd3, 1'b1, 32'h0000_0040, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_g6", 5'd6, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_done", 5'd6, 1'b0, 32'h0, 1'b1);

        // backpressure holds idx_out and ptr
        doReset();
        applyStimulus(1'b0, 1'b1, 32'h0000_0006, 1'b0);
        checkOutput("bp_load", 5'd0, 1'b0, 32'h6, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("bp_grant1", 5'd1, 1'b1, 32'h4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput($sformatf("bp_hold%0d", i), 5'd1, 1'b1, 32'h4, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("bp_grant2", 5'd2, 1'b1, 32'h0, 1'b0);

        // same-edge clear and set of bit 7
        doReset();
        applyStimulus(1'b0, 1'b1, 32'h0000_0080, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0080, 1'b1);
        checkOutput("cs_grant", 5'd7, 1'b1, 32'h0000_0080, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("cs_regrant", 5'd7, 1'b1, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("cs_done", 5'd7, 1'b0, 32'h0, 1'b1);

        // reset mid-operation beats req_load and idx_ready
        doReset();
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("mid_busy", 5'd0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("mid_busy2", 5'd1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        checkOutput("mid_reset", 5'd0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h8000_0001, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("post_reset_ptr0", 5'd0, 1'b1, 32'h8000_0000, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
